// File: rtl/imaging_mode_select_tx.sv
// Serialises a 3-bit imaging mode onto wms as mode+1 fixed-width pulses followed by a long low gap.
// Latency: first pulse one cycle after start is taken; done/ready return after the gap. start is only taken while ready=1.
module imaging_mode_select_tx #(
  parameter int unsigned PULSE_HIGH_CYCLES = 4,
  parameter int unsigned PULSE_LOW_CYCLES  = 4,
  parameter int unsigned FRAME_GAP_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] mode,
  output logic       ready,
  output logic       wms,
  output logic       done,
  output logic [2:0] current_mode
);

  // Phase counter counts down to zero, so each state is entered with its length minus one.
  localparam logic [7:0] HIGH_LOAD = 8'(PULSE_HIGH_CYCLES - 1);
  localparam logic [7:0] LOW_LOAD  = 8'(PULSE_LOW_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(FRAME_GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t     state;
  logic [7:0] phase_cnt;
  logic [3:0] pulses_left;
  logic [2:0] mode_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase_cnt    <= 8'd0;
      pulses_left  <= 4'd0;
      mode_lat     <= 3'd0;
      ready        <= 1'b1;
      wms          <= 1'b0;
      done         <= 1'b0;
      current_mode <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_lat    <= mode;
            pulses_left <= {1'b0, mode} + 4'd1;
            phase_cnt   <= HIGH_LOAD;
            state       <= HIGH;
            wms         <= 1'b1;
            ready       <= 1'b0;
          end
        end
        HIGH: begin
          if (phase_cnt == 8'd0) begin
            pulses_left <= pulses_left - 4'd1;
            wms         <= 1'b0;
            // The final pulse's trailing low is the frame gap itself.
            if (pulses_left == 4'd1) begin
              state     <= GAP;
              phase_cnt <= GAP_LOAD;
            end else begin
              state     <= LOW;
              phase_cnt <= LOW_LOAD;
            end
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        LOW: begin
          if (phase_cnt == 8'd0) begin
            state     <= HIGH;
            phase_cnt <= HIGH_LOAD;
            wms       <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        GAP: begin
          if (phase_cnt == 8'd0) begin
            state        <= IDLE;
            ready        <= 1'b1;
            done         <= 1'b1;
            current_mode <= mode_lat;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          wms   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imaging_mode_select_tx.md
IMAGING_MODE_SELECT_TX -- requirements
Module: imaging_mode_select_tx

Interface
REQ-001 Parameter: PULSE_HIGH_CYCLES, default 4, wms high time per pulse in clk cycles (legal range 1-255).
REQ-002 Parameter: PULSE_LOW_CYCLES, default 4, wms low time between pulses within one frame (legal range 1-255).
REQ-003 Parameter: FRAME_GAP_CYCLES, default 32, wms low time that terminates a frame (legal range: greater than PULSE_LOW_CYCLES, at most 255).
REQ-004 Port: clk  input  1  single system clock (50 MHz); all logic on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: start  input  1  request to transmit mode; sampled only while ready=1.
REQ-007 Port: mode  input  3  imaging mode to send (0-7); sampled with start.
REQ-008 Port: ready  output  1  transmitter idle and able to accept start.
REQ-009 Port: wms  output  1  imaging mode select line to the imaging mode state machine; driven directly from a flop.
REQ-010 Port: done  output  1  single-cycle pulse: frame fully sent, including the gap.
REQ-011 Port: current_mode  output  3  last mode whose frame completed.

Function
REQ-012 Encoding: mode M SHALL be sent as exactly M+1 wms high pulses.
REQ-013 Pulse shape: each high pulse is PULSE_HIGH_CYCLES wide, and consecutive pulses are separated by PULSE_LOW_CYCLES low.
REQ-014 Frame termination: the frame SHALL end with FRAME_GAP_CYCLES low, which replaces the final inter-pulse low.
REQ-015 State machine states: IDLE, HIGH, LOW, GAP.
REQ-016 IDLE: ready=1 and wms=0; on start=1, latch mode, load pulses_left=mode+1, and enter HIGH on the next edge.
REQ-017 HIGH: wms=1; after PULSE_HIGH_CYCLES cycles, decrement pulses_left; go to GAP if it becomes 0, otherwise go to LOW.
REQ-018 LOW: wms=0; after PULSE_LOW_CYCLES cycles, go to HIGH.
REQ-019 GAP: wms=0; after FRAME_GAP_CYCLES cycles, go to IDLE, pulse done for 1 cycle, and load current_mode from the latched mode, all on the same edge.
REQ-020 Latency: if start is accepted at edge 0, wms SHALL be 1 from cycle 1, and done=ready=1 at cycle 1+(M+1)*PULSE_HIGH_CYCLES+M*PULSE_LOW_CYCLES+FRAME_GAP_CYCLES.
REQ-021 Busy behaviour: ready SHALL be 0 in HIGH, LOW and GAP.
REQ-022 start while busy SHALL be ignored, and mode changes while busy SHALL NOT affect the frame in flight.
REQ-023 Back-to-back frames: start asserted in the same cycle that ready rises is accepted, and the next frame's first pulse begins the following cycle.
REQ-024 Counters: the phase counter SHALL be 8 bits and reload on every state entry; the pulse counter SHALL be 4 bits (max value 8), with no wrap in any legal mode.
REQ-025 done SHALL never be high for two consecutive cycles, and wms SHALL never glitch, being changed only on state transitions.

Reset
REQ-026 With rst=1 at an edge, the block SHALL go to IDLE, with wms=0, ready=1, done=0, current_mode=0, and all counters 0.
REQ-027 Reset mid-frame SHALL abort the frame: wms=0 from the next edge, no done pulse, and current_mode=0.
REQ-028 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-029 Defaults, mode=0, start at edge 0:
- wms=1 on cycles 1-4 and 0 on cycles 5-36;
- done=1 only on cycle 37, with current_mode=0.
REQ-030 Defaults, mode=7:
- exactly 8 pulses, each 4 high/4 low;
- done on cycle 93, with current_mode=7.
REQ-031 mode=3 accepted, then start=1 with mode=5 on cycle 10:
- exactly 4 pulses, with done on cycle 1+16+12+32=61;
- current_mode=3.
REQ-032 mode=2 accepted, rst=1 on cycle 6:
- wms=0 from cycle 7 and ready=1;
- done never asserted, and current_mode=0.
REQ-033 start held high continuously with mode=1:
- each frame is 1+8+4+32 cycles apart;
- the next frame's first wms rise comes one cycle after each done.
REQ-034 Parameter sweep with PULSE_HIGH_CYCLES=1, PULSE_LOW_CYCLES=1, FRAME_GAP_CYCLES=2, mode=1:
- wms pattern 1,0,1,0,0 starting cycle 1;
- done on cycle 6.
